// File: rtl/config_chain_loader_if.sv
// rtl/config_chain_loader_if.sv - host word stream and config chain signals of the loader
interface config_chain_loader_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  start;
  logic [WORD_WIDTH-1:0] word_in;
  logic                  word_valid;
  logic                  word_ready;
  logic                  cfg_data;
  logic                  cfg_enable;
  logic                  cfg_nreset;
  logic                  busy;
  logic                  done;

  // Host / bitstream source side
  modport master (
    output start, word_in, word_valid,
    input  word_ready, cfg_data, cfg_enable, cfg_nreset, busy, done
  );

  // Loader side
  modport slave (
    input  start, word_in, word_valid,
    output word_ready, cfg_data, cfg_enable, cfg_nreset, busy, done
  );
endinterface

// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - serializes host words MSB-first into a tile config shift chain
module config_chain_loader #(
  parameter int CHAIN_LENGTH = 146,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  config_chain_loader_if.slave bus
);
  localparam int CW = $clog2(CHAIN_LENGTH + 1);
  localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(CHAIN_LENGTH);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [BW-1:0] TOP_BIT    = BW'(WORD_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_WORD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         bit_count_q;
  logic [CW-1:0]         bit_count_d;
  logic [BW-1:0]         word_bit_q;
  logic [WORD_WIDTH-1:0] shift_word_q;
  logic                  cfg_data_q;
  logic                  cfg_enable_q;
  logic                  cfg_nreset_q;
  logic                  busy_q;
  logic                  done_q;

  // Shift count after the bit currently on cfg_data is clocked into the chain
  assign bit_count_d = bit_count_q + COUNT_ONE;

  // Ready is decoded from state so async reset drops it immediately
  assign bus.word_ready = (state_q == S_WAIT_WORD);
  assign bus.cfg_data   = cfg_data_q;
  assign bus.cfg_enable = cfg_enable_q;
  assign bus.cfg_nreset = cfg_nreset_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

  // Load sequencer; outputs are registered alongside the state they belong to
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      bit_count_q  <= '0;
      word_bit_q   <= '0;
      shift_word_q <= '0;
      cfg_data_q   <= 1'b0;
      cfg_enable_q <= 1'b0;
      cfg_nreset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_q      <= S_CLEAR;
            cfg_nreset_q <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        S_CLEAR: begin
          state_q      <= S_WAIT_WORD;
          bit_count_q  <= '0;
          cfg_nreset_q <= 1'b1;
        end
        S_WAIT_WORD: begin
          if (bus.word_valid) begin
            state_q      <= S_SHIFT;
            cfg_data_q   <= bus.word_in[WORD_WIDTH-1];
            shift_word_q <= bus.word_in << 1;
            word_bit_q   <= TOP_BIT;
            cfg_enable_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          // The bit on cfg_data shifts into the chain at this edge
          bit_count_q <= bit_count_d;
          if (bit_count_d == LAST_COUNT) begin
            state_q      <= S_DONE;
            cfg_enable_q <= 1'b0;
            cfg_data_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
          end else if (word_bit_q == '0) begin
            state_q      <= S_WAIT_WORD;
            cfg_enable_q <= 1'b0;
            cfg_data_q   <= 1'b0;
          end else begin
            cfg_data_q   <= shift_word_q[WORD_WIDTH-1];
            shift_word_q <= shift_word_q << 1;
            word_bit_q   <= word_bit_q - BIT_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - table-driven and directed checks of config_chain_loader
module tb_config_chain_loader;
  logic clk;
  logic rst;

  config_chain_loader_if #(.WORD_WIDTH(8)) bus1 ();
  config_chain_loader_if #(.WORD_WIDTH(8)) bus2 ();

  config_chain_loader #(.CHAIN_LENGTH(146), .WORD_WIDTH(8)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1.slave)
  );

  config_chain_loader #(.CHAIN_LENGTH(16), .WORD_WIDTH(8)) dut2 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus2.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model of the tile config chains being loaded
  logic [145:0] chain1;
  logic [15:0]  chain2;

  always @(posedge clk) begin
    if (!bus1.cfg_nreset) chain1 <= '0;
    else if (bus1.cfg_enable) chain1 <= {chain1[144:0], bus1.cfg_data};
    if (!bus2.cfg_nreset) chain2 <= '0;
    else if (bus2.cfg_enable) chain2 <= {chain2[14:0], bus2.cfg_data};
  end

  int total;
  int bad;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int           gap;
    logic [7:0]   base;
    logic [7:0]   step;
    int           mid_at;
    logic [145:0] exp_chain;
    int           exp_en;
    int           exp_acc;
    int           exp_cyc;
  } vec_t;

  vec_t vecs [4];

  localparam logic [145:0] INC_CHAIN = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                        8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                                        8'h10, 8'h11, 2'b00};

  task automatic do_load(input int gap, input logic [7:0] base, input logic [7:0] step,
                         input int mid_at, output int n_en, output int n_acc, output int n_cyc,
                         output int n_clr, output int n_en_wait, output int n_idle,
                         output int done_gap, output logic done_first);
    int k;
    int last_en;
    bit got_done;
    k = 0; n_en = 0; n_clr = 0; n_en_wait = 0; n_idle = 0;
    last_en = -100; got_done = 0; done_gap = -1; n_cyc = -1; done_first = 1'b1;
    @(negedge clk);
    bus1.start = 1'b1;
    bus1.word_valid = 1'b0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      @(negedge clk);
      bus1.start = 1'b0;
      if (c == 0) done_first = bus1.done;
      if (bus1.done) begin
        got_done = 1;
        done_gap = c - last_en;
        n_cyc = c;
      end else begin
        if (!bus1.cfg_nreset) n_clr++;
        if (bus1.cfg_enable) begin
          n_en++;
          last_en = c;
        end
        if (bus1.cfg_enable && bus1.word_ready) n_en_wait++;
        if (!bus1.busy) n_idle++;
        if (mid_at >= 0 && bus1.cfg_enable && n_en == mid_at) bus1.start = 1'b1;
        bus1.word_valid = ((c % gap) == 0);
        bus1.word_in = base + step * 8'(k);
        if (bus1.word_valid && bus1.word_ready) k++;
      end
    end
    bus1.word_valid = 1'b0;
    n_acc = k;
  endtask

  int n_en, n_acc, n_cyc, n_clr, n_en_wait, n_idle, done_gap;
  logic done_first;
  logic [7:0] w2 [3];

  initial begin
    total = 0;
    bad = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus1.start = 1'b0; bus1.word_in = '0; bus1.word_valid = 1'b0;
    bus2.start = 1'b0; bus2.word_in = '0; bus2.word_valid = 1'b0;

    vecs[0] = '{gap: 1, base: 8'h00, step: 8'h01, mid_at: -1, exp_chain: INC_CHAIN,
                exp_en: 146, exp_acc: 19, exp_cyc: 166};
    vecs[1] = '{gap: 5, base: 8'h00, step: 8'h01, mid_at: -1, exp_chain: INC_CHAIN,
                exp_en: 146, exp_acc: 19, exp_cyc: 188};
    vecs[2] = '{gap: 1, base: 8'hFF, step: 8'h00, mid_at: -1, exp_chain: {146{1'b1}},
                exp_en: 146, exp_acc: 19, exp_cyc: 166};
    vecs[3] = '{gap: 1, base: 8'h00, step: 8'h01, mid_at: 50, exp_chain: INC_CHAIN,
                exp_en: 146, exp_acc: 19, exp_cyc: 166};

    #12;
    check("rst_ready", 160'(bus1.word_ready), 160'(0));
    check("rst_data", 160'(bus1.cfg_data), 160'(0));
    check("rst_enable", 160'(bus1.cfg_enable), 160'(0));
    check("rst_nreset", 160'(bus1.cfg_nreset), 160'(1));
    check("rst_busy", 160'(bus1.busy), 160'(0));
    check("rst_done", 160'(bus1.done), 160'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      do_load(vecs[i].gap, vecs[i].base, vecs[i].step, vecs[i].mid_at,
              n_en, n_acc, n_cyc, n_clr, n_en_wait, n_idle, done_gap, done_first);
      check($sformatf("v%0d_chain", i), 160'(chain1), 160'(vecs[i].exp_chain));
      check($sformatf("v%0d_enables", i), 160'(n_en), 160'(vecs[i].exp_en));
      check($sformatf("v%0d_accepts", i), 160'(n_acc), 160'(vecs[i].exp_acc));
      check($sformatf("v%0d_cycles", i), 160'(n_cyc), 160'(vecs[i].exp_cyc));
      check($sformatf("v%0d_clear_cycles", i), 160'(n_clr), 160'(1));
      check($sformatf("v%0d_enable_in_wait", i), 160'(n_en_wait), 160'(0));
      check($sformatf("v%0d_not_busy", i), 160'(n_idle), 160'(0));
      check($sformatf("v%0d_done_latency", i), 160'(done_gap), 160'(1));
      check($sformatf("v%0d_done_dropped", i), 160'(done_first), 160'(0));
      @(negedge clk);
      check($sformatf("v%0d_done_held", i), 160'(bus1.done), 160'(1));
    end

    // Reset abandons a load after 50 shifts; the chain keeps its partial contents
    @(negedge clk);
    bus1.start = 1'b1;
    n_en = 0;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 500 && n_en < 50; c++) begin
        @(negedge clk);
        bus1.start = 1'b0;
        if (bus1.cfg_enable) n_en++;
        bus1.word_valid = 1'b1;
        bus1.word_in = 8'hA0 + 8'(k);
        if (bus1.word_ready) k++;
      end
    end
    check("rst_mid_reached50", 160'(n_en), 160'(50));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_enable", 160'(bus1.cfg_enable), 160'(0));
    check("rst_mid_ready", 160'(bus1.word_ready), 160'(0));
    check("rst_mid_busy", 160'(bus1.busy), 160'(0));
    check("rst_mid_done", 160'(bus1.done), 160'(0));
    check("rst_mid_partial", 160'(chain1[49:0]),
          160'({8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 2'b10}));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus1.word_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_retained", 160'(chain1[49:0]),
          160'({8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 2'b10}));
    check("rst_mid_idle_enable", 160'(bus1.cfg_enable), 160'(0));
    do_load(1, 8'h00, 8'h01, -1, n_en, n_acc, n_cyc, n_clr, n_en_wait, n_idle, done_gap, done_first);
    check("reload_chain", 160'(chain1), 160'(INC_CHAIN));
    check("reload_enables", 160'(n_en), 160'(146));
    check("reload_clear_cycles", 160'(n_clr), 160'(1));

    // Short chain: two words exactly fill it, third offered word is never taken
    w2[0] = 8'hA5; w2[1] = 8'h3C; w2[2] = 8'h77;
    @(negedge clk);
    bus2.start = 1'b1;
    begin
      int k;
      int en2;
      int last_en;
      int gap2;
      bit got;
      k = 0; en2 = 0; last_en = -100; gap2 = -1; got = 0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clk);
        bus2.start = 1'b0;
        if (bus2.done) begin
          got = 1;
          gap2 = c - last_en;
        end else begin
          if (bus2.cfg_enable) begin
            en2++;
            last_en = c;
          end
          bus2.word_valid = 1'b1;
          bus2.word_in = (k < 3) ? w2[k] : 8'h00;
          if (bus2.word_ready) k++;
        end
      end
      bus2.word_valid = 1'b0;
      check("short_accepts", 160'(k), 160'(2));
      check("short_enables", 160'(en2), 160'(16));
      check("short_chain", 160'(chain2), 160'(16'hA53C));
      check("short_done_latency", 160'(gap2), 160'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Sequencer that loads a logic tile's serial configuration shift chain from a word-wide host stream.
- On start it clears the chain, then accepts words over a valid/ready handshake. It serializes each word MSB-first onto the chain's data/enable inputs and stops after exactly CHAIN_LENGTH shifts.
- Sits between the bitstream source (host/ROM reader) and one or more daisy-chained tile config registers.

Parameters:
- CHAIN_LENGTH, 146: total number of config bits in the chain; exact number of shift pulses issued per load.
- WORD_WIDTH, 8: width of the host word.

Ports:
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load when in IDLE or DONE.
- word_in  input  WORD_WIDTH  configuration word; bit WORD_WIDTH-1 is shifted first.
- word_valid  input  1  word_in holds a valid word.
- word_ready  output  1  loader can accept a word this cycle.
- cfg_data  output  1  serial bit to the chain's data_in.
- cfg_enable  output  1  shift enable to the chain.
- cfg_nreset  output  1  active-low synchronous clear to the chain.
- busy  output  1  load in progress (CLEAR, WAIT_WORD, SHIFT).
- done  output  1  chain fully loaded; held until the next start.

Behaviour:
- Reset (async, immediate):
  - State IDLE; counters 0.
  - Outputs: word_ready=0, cfg_data=0, cfg_enable=0, cfg_nreset=1, busy=0, done=0.
  - Reset mid-load abandons the load; the chain retains partial contents, with no further shifts.
- All outputs are registered, except word_ready, which is decoded from state (high iff state==WAIT_WORD).
- IDLE:
  - start=1 -> CLEAR.
  - word_valid is ignored.
- CLEAR (exactly 1 cycle):
  - cfg_nreset=0, cfg_enable=0, busy=1.
  - Clears bit_count (0..CHAIN_LENGTH) -> WAIT_WORD.
- WAIT_WORD:
  - word_ready=1, cfg_enable=0.
  - On word_valid&word_ready: latch word_in into shift_word, set word_bit=WORD_WIDTH-1 -> SHIFT.
  - No bubble requirement beyond the state change.
- SHIFT (one bit per cycle):
  - cfg_enable=1; cfg_data=shift_word[WORD_WIDTH-1]; shift_word shifts left by 1; bit_count++.
  - If bit_count reaches CHAIN_LENGTH on this shift -> DONE. Any unsent low-order bits of the current word are discarded.
  - Else if word_bit==0 -> WAIT_WORD.
  - Else word_bit--.
  - Each accepted word therefore costs WORD_WIDTH shift cycles plus 1 handshake cycle.
- DONE:
  - done=1, busy=0, cfg_enable=0, word_ready=0.
  - start=1 -> CLEAR, with done dropping in the same transition.
- Bit placement:
  - The first bit shifted ends at chain bit CHAIN_LENGTH-1; the last ends at bit 0.
  - Word count = ceil(CHAIN_LENGTH/WORD_WIDTH).
  - Only the top (CHAIN_LENGTH mod WORD_WIDTH) bits of the final word are used when the division is inexact.
- cfg_enable is never asserted for more than CHAIN_LENGTH cycles per load, and never in the same cycle as cfg_nreset=0.
- start while busy: ignored; the load continues unaffected.
- word_valid held high continuously: a new word is accepted on every WAIT_WORD cycle with no stall.
- bit_count width: clog2(CHAIN_LENGTH+1). No wrap-around; the terminal compare is exact equality.

Test Plan:
- Reset, then start, with CHAIN_LENGTH=146 and WORD_WIDTH=8; feed 19 words 0x00..0x12 with word_valid always high:
  - exactly 146 cfg_enable cycles;
  - done rises 1 cycle after the 146th shift;
  - chain contents [145:138]=0x00 ... [9:2]=0x11, [1:0]=0x12 bits 7:6 (=00);
  - word_ready is never high again after the 19th accept.
- Same load with word_valid gapped (valid 1 cycle in every 5):
  - identical final chain contents;
  - cfg_enable is never high during WAIT_WORD;
  - total cycles = 146 + 19 handshakes + stalls.
- start pulse during SHIFT: no CLEAR, shift count still 146, done asserted once.
- Assert reset after 50 shifts:
  - cfg_enable=0 and word_ready=0 immediately (asynchronously, before the next clock edge);
  - busy=0, done=0;
  - new start gives cfg_nreset low for 1 cycle, then a full 146-bit load.
- After DONE, pulse start:
  - done falls;
  - cfg_nreset=0 for exactly one cycle;
  - second load with 0xFF words yields an all-ones chain.
- Parameter variant CHAIN_LENGTH=16, WORD_WIDTH=8: exactly 2 words accepted, 16 shifts, no discarded bits, done after the last shift.
